// File: rtl/capsense_pkg.sv
// Shared state encoding and width helpers for the capacitive-sense scan controller.
package capsense_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_DISCHARGE = 3'd1;
   localparam state_t ST_MEASURE   = 3'd2;
   localparam state_t ST_EVAL      = 3'd3;
   localparam state_t ST_GAP       = 3'd4;

   // Index width for n items, never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a timer that must count up to the larger of two cycle budgets.
   function automatic int unsigned cyc_w(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/capsense_chan_state.sv
// Per-pad calibration and touch state: baseline tracking, threshold compare, debounce.
module capsense_chan_state
   import capsense_pkg::*;
#(
   parameter int unsigned CNT_W    = 12,
   parameter int unsigned THRESH   = 32,
   parameter int unsigned DEBOUNCE = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             eval_i,
   input  logic             cal_i,
   input  logic [CNT_W-1:0] count_i,
   output logic             pressed_o
);

   localparam int unsigned DEB_W = idx_w(DEBOUNCE + 1);

   logic [CNT_W-1:0] baseline, baseline_nxt;
   logic             valid, valid_nxt;
   logic [DEB_W-1:0] deb, deb_nxt;
   logic             pressed_nxt;
   logic             reload;
   logic             raw;
   logic [CNT_W:0]   limit;
   logic [DEB_W-1:0] deb_inc;

   // A reload makes the count its own baseline, so it never reads as a touch.
   always_comb begin
      baseline_nxt = baseline;
      valid_nxt    = valid;
      deb_nxt      = deb;
      pressed_nxt  = pressed_o;
      reload       = cal_i || !valid;
      limit        = {1'b0, baseline} + (CNT_W+1)'(THRESH);
      raw          = !reload && ({1'b0, count_i} > limit);
      deb_inc      = deb + DEB_W'(1);
      if (eval_i) begin
         if (reload) begin
            baseline_nxt = count_i;
            valid_nxt    = 1'b1;
         end else if (count_i < baseline) begin
            baseline_nxt = count_i;
         end
         if (raw != pressed_o) begin
            if (deb_inc == DEB_W'(DEBOUNCE)) begin
               pressed_nxt = ~pressed_o;
               deb_nxt     = '0;
            end else begin
               deb_nxt = deb_inc;
            end
         end else begin
            deb_nxt = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         baseline  <= '0;
         valid     <= 1'b0;
         deb       <= '0;
         pressed_o <= 1'b0;
      end else begin
         baseline  <= baseline_nxt;
         valid     <= valid_nxt;
         deb       <= deb_nxt;
         pressed_o <= pressed_nxt;
      end
   end

endmodule

// File: rtl/capsense_scan_ctrl.sv
// Time-multiplexed capacitive pad scanner: discharge, release one pad, count charge time.
module capsense_scan_ctrl
   import capsense_pkg::*;
#(
   parameter int unsigned N             = 4,
   parameter int unsigned CNT_W         = 12,
   parameter int unsigned DISCHARGE_CYC = 64,
   parameter int unsigned TIMEOUT       = 4095,
   parameter int unsigned THRESH        = 32,
   parameter int unsigned DEBOUNCE      = 3,
   parameter int unsigned SCAN_GAP      = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic                 recal_i,
   input  logic [N-1:0]         pad_i,
   output logic [N-1:0]         pad_oe_o,
   output logic [N-1:0]         pressed_o,
   output logic [CNT_W-1:0]     count_o,
   output logic [idx_w(N)-1:0]  count_ch_o,
   output logic                 count_valid_o,
   output logic [N-1:0]         timeout_o,
   output logic                 busy_o
);

   localparam int unsigned CH_W  = idx_w(N);
   localparam int unsigned TMR_W = cyc_w(DISCHARGE_CYC, SCAN_GAP);

   state_t           state, state_nxt;
   logic [CH_W-1:0]  ch, ch_nxt;
   logic [TMR_W-1:0] tmr, tmr_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             meas_tmo, meas_tmo_nxt;
   logic             cal_pending, cal_pending_nxt;
   logic             scan_cal, scan_cal_nxt;
   logic [N-1:0]     sync1, sync2;
   logic             start;
   logic [N-1:0]     pad_oe_nxt;
   logic [CNT_W-1:0] count_nxt;
   logic [CH_W-1:0]  count_ch_nxt;
   logic             count_valid_nxt;
   logic [N-1:0]     timeout_nxt;
   logic             busy_nxt;

   // Next-state and registered-output logic.
   always_comb begin
      state_nxt       = state;
      ch_nxt          = ch;
      tmr_nxt         = tmr;
      cnt_nxt         = cnt;
      meas_tmo_nxt    = meas_tmo;
      scan_cal_nxt    = scan_cal;
      cal_pending_nxt = cal_pending | recal_i;
      count_nxt       = count_o;
      count_ch_nxt    = count_ch_o;
      count_valid_nxt = 1'b0;
      timeout_nxt     = timeout_o;
      start           = 1'b0;
      pad_oe_nxt      = '1;

      case (state)
         ST_IDLE: begin
            if (en_i) start = 1'b1;
         end
         ST_DISCHARGE: begin
            if (tmr == TMR_W'(DISCHARGE_CYC - 1)) begin
               state_nxt    = ST_MEASURE;
               cnt_nxt      = '0;
               meas_tmo_nxt = 1'b0;
            end else begin
               tmr_nxt = tmr + TMR_W'(1);
            end
         end
         ST_MEASURE: begin
            if (sync2[ch]) begin
               state_nxt = ST_EVAL;
            end else if (cnt == CNT_W'(TIMEOUT)) begin
               state_nxt    = ST_EVAL;
               meas_tmo_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_EVAL: begin
            count_nxt       = cnt;
            count_ch_nxt    = ch;
            count_valid_nxt = 1'b1;
            timeout_nxt[ch] = meas_tmo;
            tmr_nxt         = '0;
            if (ch == CH_W'(N - 1)) begin
               state_nxt = ST_GAP;
            end else begin
               state_nxt = ST_DISCHARGE;
               ch_nxt    = ch + CH_W'(1);
            end
         end
         ST_GAP: begin
            if (tmr == TMR_W'(SCAN_GAP - 1)) begin
               if (en_i) start = 1'b1;
               else      state_nxt = ST_IDLE;
            end else begin
               tmr_nxt = tmr + TMR_W'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // A scan latches the pending recal at its start, so a mid-scan pulse waits a scan.
      if (start) begin
         state_nxt       = ST_DISCHARGE;
         ch_nxt          = '0;
         tmr_nxt         = '0;
         scan_cal_nxt    = cal_pending;
         cal_pending_nxt = recal_i;
      end

      if (state_nxt == ST_MEASURE) pad_oe_nxt[ch_nxt] = 1'b0;
      busy_nxt = (state_nxt == ST_DISCHARGE) || (state_nxt == ST_MEASURE) ||
                 (state_nxt == ST_EVAL);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= ST_IDLE;
         ch            <= '0;
         tmr           <= '0;
         cnt           <= '0;
         meas_tmo      <= 1'b0;
         cal_pending   <= 1'b1;
         scan_cal      <= 1'b0;
         sync1         <= '0;
         sync2         <= '0;
         pad_oe_o      <= '1;
         count_o       <= '0;
         count_ch_o    <= '0;
         count_valid_o <= 1'b0;
         timeout_o     <= '0;
         busy_o        <= 1'b0;
      end else begin
         state         <= state_nxt;
         ch            <= ch_nxt;
         tmr           <= tmr_nxt;
         cnt           <= cnt_nxt;
         meas_tmo      <= meas_tmo_nxt;
         cal_pending   <= cal_pending_nxt;
         scan_cal      <= scan_cal_nxt;
         sync1         <= pad_i;
         sync2         <= sync1;
         pad_oe_o      <= pad_oe_nxt;
         count_o       <= count_nxt;
         count_ch_o    <= count_ch_nxt;
         count_valid_o <= count_valid_nxt;
         timeout_o     <= timeout_nxt;
         busy_o        <= busy_nxt;
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_chan
      capsense_chan_state #(
         .CNT_W    (CNT_W),
         .THRESH   (THRESH),
         .DEBOUNCE (DEBOUNCE)
      ) u_chan (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .eval_i    ((state == ST_EVAL) && (ch == CH_W'(g))),
         .cal_i     (scan_cal),
         .count_i   (cnt),
         .pressed_o (pressed_o[g])
      );
   end

endmodule
